// File: rtl/logic_sweep_checker_pkg.sv
// Shared types and golden function for the exhaustive 2-input logic sweep.
// Mode encodings, FSM states and latency limits live here.
package logic_sweep_checker_pkg;

  typedef enum logic [1:0] {
    MODE_NOR  = 2'b00,
    MODE_NAND = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_AND  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int MAX_LATENCY = 4;
  localparam int DCNT_W      = 3;

  // Bitwise, so applied per bit for any operand width.
  function automatic logic golden(
    input mode_t m,
    input logic  a,
    input logic  b
  );
    logic r;
    r = 1'b0;
    unique case (m)
      MODE_NOR:  r = ~(a | b);
      MODE_NAND: r = ~(a & b);
      MODE_XOR:  r = a ^ b;
      MODE_AND:  r = a & b;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_sweep_delay.sv
// Valid+data shift register that aligns {idx, expected} with the
// result coming back from the logic unit under test.
module logic_sweep_delay #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic          vld [DEPTH];
  logic [DW-1:0] dat [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld[i] <= 1'b0;
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/logic_sweep_checker.sv
// Exhaustive truth-table sweep engine: drives every {A,B} to an external
// logic unit and scores its delayed result against the golden function.
module logic_sweep_checker
  import logic_sweep_checker_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 2*WIDTH+1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               stim_valid,
  input  logic [WIDTH-1:0]   dut_res,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic               fail_seen,
  output logic [2*WIDTH-1:0] first_fail_idx,
  output logic               pass
);

  localparam int IW = 2*WIDTH;
  localparam int PW = IW + WIDTH;
  localparam logic [IW:0] LAST = (IW+1)'((64'd1 << IW) - 64'd1);
  localparam logic [DCNT_W-1:0] DRAIN_END = DCNT_W'(LATENCY);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("LATENCY out of range");
  end

  state_t             state;
  mode_t              mode_q;
  logic [IW:0]        idx;
  logic [DCNT_W-1:0]  dcnt;
  logic [WIDTH-1:0]   gold;
  logic [PW-1:0]      pipe_in;
  logic [PW-1:0]      pipe_out;
  logic               pipe_valid;
  logic [IW-1:0]      exp_idx;
  logic [WIDTH-1:0]   exp_res;
  logic               mismatch;
  logic [CNT_W-1:0]   err_next;

  always_comb begin
    gold = '0;
    for (int j = 0; j < WIDTH; j++) begin
      gold[j] = golden(mode_q, a_out[j], b_out[j]);
    end
  end

  // Golden is formed from the registered operands so the delay line
  // lines up with the unit's LATENCY counted from stimulus presentation.
  assign pipe_in = {a_out, b_out, gold};

  logic_sweep_delay #(
    .DEPTH (LATENCY),
    .DW    (PW)
  ) u_delay (
    .clk       (clk),
    .rst       (reset),
    .in_valid  (stim_valid),
    .in_data   (pipe_in),
    .out_valid (pipe_valid),
    .out_data  (pipe_out)
  );

  assign exp_idx  = pipe_out[PW-1:WIDTH];
  assign exp_res  = pipe_out[WIDTH-1:0];
  assign mismatch = pipe_valid && (dut_res != exp_res);
  assign err_next = err_count + CNT_W'(mismatch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      mode_q         <= MODE_NOR;
      idx            <= '0;
      dcnt           <= '0;
      a_out          <= '0;
      b_out          <= '0;
      stim_valid     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      fail_seen      <= 1'b0;
      first_fail_idx <= '0;
      pass           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mismatch) begin
        err_count <= err_next;
        if (!fail_seen) begin
          fail_seen      <= 1'b1;
          first_fail_idx <= exp_idx;
        end
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mode_q         <= mode_t'(mode);
            err_count      <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
            idx            <= '0;
            busy           <= 1'b1;
            state          <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          stim_valid <= 1'b1;
          a_out      <= idx[IW-1:WIDTH];
          b_out      <= idx[WIDTH-1:0];
          idx        <= idx + 1'b1;
          if (idx == LAST) begin
            dcnt  <= '0;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          stim_valid <= 1'b0;
          if (dcnt == DRAIN_END) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_next == '0);
            state <= S_DONE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
